// File: rtl/gpu_vram_readback.sv
// gpu_vram_readback
//   Return path for the VRAM->CPU rectangle copy. It walks the latched rectangle
//   in row-major order, issues halfword reads to VRAM and packs pixel pairs into
//   32-bit GPUREAD words in a small word FIFO. The CPU or DMA drains that FIFO.
//
// Parameters
//   FIFO_DEPTH  GPUREAD word FIFO entries (power of 2, >= 4)
//   MAX_OUTST   maximum VRAM halfword reads in flight
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, rect_x/y/w/h              launch pulse and rectangle (w,h pre-masked 1..)
//   abort                            cancel the transfer and flush the FIFO
//   vram_rd_req/addr/gnt             VRAM read request handshake
//   vram_rd_valid/data               in-order read return
//   gpuread_re, gpuread_data         GPUREAD pop strobe and value
//   img_rdy, busy, dma_req, dma_dir  status flags and DMA request
module gpu_vram_readback #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  rect_x,
  input  logic [8:0]  rect_y,
  input  logic [10:0] rect_w,
  input  logic [9:0]  rect_h,
  input  logic        abort,
  output logic        vram_rd_req,
  output logic [19:0] vram_addr,
  input  logic        vram_rd_gnt,
  input  logic        vram_rd_valid,
  input  logic [15:0] vram_rd_data,
  input  logic        gpuread_re,
  output logic [31:0] gpuread_data,
  output logic        img_rdy,
  output logic        busy,
  output logic        dma_req,
  input  logic [1:0]  dma_dir
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_EMPTYW} state_t;

  state_t          state, state_n;
  logic            pend;
  logic [9:0]      lat_x;
  logic [8:0]      lat_y;
  logic [10:0]     lat_w;
  logic [19:0]     total;
  logic [9:0]      col;
  logic [8:0]      row;
  logic [19:0]     req_cnt;
  logic [19:0]     rcv_cnt;
  logic [OW-1:0]   outst;
  logic            half;
  logic [15:0]     lo_pix;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt, cnt_n;
  logic [31:0]     last_pop;

  logic            start_acc, launch, grant, accept, last_req, last_pix;
  logic            push, pop;
  logic [31:0]     push_word;
  logic [7:0]      words_pend;
  logic [15:0]     fifo_need;

  assign start_acc = start & ~abort & (state == S_IDLE);
  // A start held while discarded returns are still in flight launches once
  // the outstanding count drains to zero.
  assign launch    = (state == S_IDLE) & ~abort & (start | pend) & (outst == '0);

  // Words the FIFO must still absorb if one more read is issued: every
  // in-flight halfword plus a held low halfword plus the new one, paired.
  assign words_pend = (8'(outst) + 8'(half) + 8'd2) >> 1;
  assign fifo_need  = 16'(fifo_cnt) + 16'(words_pend);

  assign vram_rd_req = (state == S_FETCH) & ~abort &
                       (int'(outst) < MAX_OUTST) &
                       (fifo_need <= 16'(FIFO_DEPTH));
  assign vram_addr   = {1'b0, lat_y + row, lat_x + col};

  assign grant    = vram_rd_req & vram_rd_gnt;
  assign last_req = (req_cnt == total - 20'd1);
  assign accept   = vram_rd_valid & ~abort & ((state == S_FETCH) | (state == S_DRAIN));
  assign last_pix = (rcv_cnt == total - 20'd1);

  // A word completes on the high halfword, or on a lone final pixel.
  assign push      = accept & (half | last_pix);
  assign push_word = half ? {vram_rd_data, lo_pix} : {16'h0000, vram_rd_data};
  assign pop       = gpuread_re & (fifo_cnt != '0) & ~abort;

  always_comb begin
    cnt_n = fifo_cnt;
    if (abort)            cnt_n = '0;
    else if (push & ~pop) cnt_n = fifo_cnt + CW'(1);
    else if (pop & ~push) cnt_n = fifo_cnt - CW'(1);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (launch) state_n = S_FETCH;
      S_FETCH:  if (grant & last_req) state_n = S_DRAIN;
      S_DRAIN:  if (push & last_pix) state_n = S_EMPTYW;
      S_EMPTYW: if (fifo_cnt == '0) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  assign busy         = (state != S_IDLE);
  assign gpuread_data = img_rdy ? mem[rd_ptr] : last_pop;

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pend     <= 1'b0;
      col      <= '0;
      row      <= '0;
      req_cnt  <= '0;
      rcv_cnt  <= '0;
      outst    <= '0;
      half     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      last_pop <= '0;
      img_rdy  <= 1'b0;
      dma_req  <= 1'b0;
    end else begin
      state <= state_n;

      if (abort | launch) pend <= 1'b0;
      else if (start_acc) pend <= 1'b1;

      if (start_acc) begin
        col     <= '0;
        row     <= '0;
        req_cnt <= '0;
      end else if (grant) begin
        req_cnt <= req_cnt + 20'd1;
        if ({1'b0, col} == lat_w - 11'd1) begin
          col <= '0;
          row <= row + 9'd1;
        end else begin
          col <= col + 10'd1;
        end
      end

      if (start_acc)   rcv_cnt <= '0;
      else if (accept) rcv_cnt <= rcv_cnt + 20'd1;

      if (abort | start_acc) half <= 1'b0;
      else if (accept)       half <= ~half & ~last_pix;

      // Discarded returns after abort still retire here.
      if (grant & ~vram_rd_valid)      outst <= outst + OW'(1);
      else if (~grant & vram_rd_valid) outst <= outst - OW'(1);

      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_cnt <= cnt_n;

      if (pop) last_pop <= mem[rd_ptr];

      img_rdy <= (cnt_n != '0);
      dma_req <= (cnt_n != '0) & (dma_dir == 2'b11);
    end
  end

  // Datapath storage
  always_ff @(posedge clk) begin
    if (start_acc) begin
      lat_x <= rect_x;
      lat_y <= rect_y;
      lat_w <= rect_w;
      total <= 20'(rect_w) * 20'(rect_h);
    end
    if (accept & ~half) lo_pix <= vram_rd_data;
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule
